// File: rtl/solver_io_pkg.sv
// Shared definitions for the solver result I/O path.
//   ASC_*      : ASCII constants used by the hex formatter
//   fmt_state_t: formatter FSM encoding (IDLE=0, DIGIT=1, SEP=2)
//   hex_ascii  : 4-bit nibble -> upper-case ASCII hex digit
package solver_io_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_LF = 8'h0A;

    // State names carry an S_ prefix so they never collide with the SEP byte parameter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_SEP   = 2'd2
    } fmt_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASC_0 + {4'h0, nib};
        else
            return ASC_A + ({4'h0, nib} - 8'd10);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with separate read/write pointers and a count.
// Ports:
//   clock, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  : write request and data; ignored while full
//   pop              : read request; ignored while empty
//   head             : oldest entry, valid whenever !empty
//   full, empty      : registered occupancy flags (decoded from count)
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/hex_line_formatter.sv
// Buffers solver result words and renders each as upper-case ASCII hex
// (MSB nibble first, leading zeros kept) followed by one separator byte,
// streamed to the JTAG-UART bridge byte port.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   in_valid/in_data   : result word offer; accepted when in_valid && in_ready
//   in_ready           : FIFO not full (registered state only)
//   serial_ready       : bridge accepts a byte this cycle
//   serial_send        : registered byte-valid
//   serial_dataToSend  : registered ASCII byte
//   busy               : FIFO non-empty or a line in progress
module hex_line_formatter
    import solver_io_pkg::*;
#(
    parameter int         WORD_W     = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SEP        = ASC_LF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              serial_ready,
    output logic              serial_send,
    output logic [7:0]        serial_dataToSend,
    output logic              busy
);

    localparam int NDIG   = WORD_W / 4;
    localparam int DCNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;

    fmt_state_t        state, state_n;
    logic [WORD_W-1:0] sh, sh_n, sh_shl;
    logic [DCNT_W-1:0] dcnt, dcnt_n;
    logic              send_q, send_n;
    logic [7:0]        byte_q, byte_n;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            sh     <= '0;
            dcnt   <= '0;
            send_q <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            dcnt   <= dcnt_n;
            send_q <= send_n;
            byte_q <= byte_n;
        end
    end

    // The next byte is precomputed from the shifted word so the output byte
    // is a plain register that only changes on a transfer.
    assign sh_shl = sh << 4;

    always_comb begin
        state_n  = state;
        sh_n     = sh;
        dcnt_n   = dcnt;
        send_n   = send_q;
        byte_n   = byte_q;
        fifo_pop = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_n     = fifo_head;
                    dcnt_n   = DCNT_W'(NDIG - 1);
                    send_n   = 1'b1;
                    byte_n   = hex_ascii(fifo_head[WORD_W-1 -: 4]);
                    state_n  = S_DIGIT;
                end
            end
            S_DIGIT: begin
                // serial_send is always high here, so serial_ready alone marks a transfer.
                if (serial_ready) begin
                    sh_n = sh_shl;
                    if (dcnt == '0) begin
                        byte_n  = SEP;
                        state_n = S_SEP;
                    end else begin
                        dcnt_n = dcnt - 1'b1;
                        byte_n = hex_ascii(sh_shl[WORD_W-1 -: 4]);
                    end
                end
            end
            S_SEP: begin
                if (serial_ready) begin
                    send_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                send_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign serial_send       = send_q;
    assign serial_dataToSend = byte_q;
    assign busy              = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_hex_line_formatter.sv
module tb_hex_line_formatter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        serial_ready;
    logic        serial_send;
    logic [7:0]  serial_dataToSend;
    logic        busy;

    hex_line_formatter dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .serial_ready      (serial_ready),
        .serial_send       (serial_send),
        .serial_dataToSend (serial_dataToSend),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transfer log: sampled at negedge, inputs only change at posedge+1.
    logic [7:0] q[$];
    int         qc[$];
    always @(negedge clock) begin
        if (!reset && serial_send && serial_ready) begin
            q.push_back(serial_dataToSend);
            qc.push_back(cyc);
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [71:0] exp;   // nine bytes, first byte in the MSBs
    } vec_t;
    vec_t tbl[6];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer a word and hold it until accepted; t = cycle in which it was accepted.
    task automatic push_word(input logic [31:0] w, output int t);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_accept_timeout", 32'(in_ready), 32'd1);
        t = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("byte_wait_timeout", 32'(q.size() >= n), 32'd1);
    endtask

    task automatic check_line(input int base, input int idx);
        logic [71:0] e;
        e = tbl[idx].exp;
        for (int i = 0; i < 9; i++) begin
            if (base + i < q.size())
                check($sformatf("line%0d_byte%0d", idx, i), 32'(q[base+i]), 32'(e[71-8*i -: 8]));
            else
                check($sformatf("line%0d_byte%0d_missing", idx, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        int t;
        tbl[0] = '{32'h1234ABCD, {"1234ABCD", 8'h0A}};
        tbl[1] = '{32'h0000000F, {"0000000F", 8'h0A}};
        tbl[2] = '{32'hDEADBEEF, {"DEADBEEF", 8'h0A}};
        tbl[3] = '{32'hFFFFFFFF, {"FFFFFFFF", 8'h0A}};
        tbl[4] = '{32'h00000000, {"00000000", 8'h0A}};
        tbl[5] = '{32'h89ABC765, {"89ABC765", 8'h0A}};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; serial_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_send",     32'(serial_send),       32'd0);
        check("rst_data",     32'(serial_dataToSend), 32'd0);
        check("rst_busy",     32'(busy),              32'd0);
        check("rst_in_ready", 32'(in_ready),          32'd1);
        reset = 1'b0;
        tick();

        // Single words with the bridge always ready: latency, content, no gaps.
        for (int v = 0; v < 6; v++) begin
            q.delete(); qc.delete();
            push_word(tbl[v].word, t);
            check($sformatf("v%0d_send_t1", v), 32'(serial_send), 32'd0);
            tick();
            check($sformatf("v%0d_latency", v), 32'(cyc - t), 32'd2);
            check($sformatf("v%0d_send_t2", v), 32'(serial_send), 32'd1);
            wait_bytes(9, 40);
            check_line(0, v);
            if (qc.size() >= 9)
                check($sformatf("v%0d_consecutive", v), 32'(qc[8] - qc[0]), 32'd8);
            tick();
            check($sformatf("v%0d_send_after", v), 32'(serial_send), 32'd0);
            check($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_len", v), 32'(q.size()), 32'd9);
        end

        // Backpressure: one word sits in the shift register, four fill the FIFO,
        // the sixth is held by the producer until space opens.
        q.delete(); qc.delete();
        serial_ready = 1'b0;
        for (int v = 0; v < 5; v++) push_word(tbl[v].word, t);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        in_data = tbl[5].word; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_no_bytes", 32'(q.size()), 32'd0);
        serial_ready = 1'b1;
        push_word(tbl[5].word, t);
        wait_bytes(54, 200);
        for (int v = 0; v < 6; v++) check_line(9 * v, v);
        tick(); tick();
        check("bp_total", 32'(q.size()), 32'd54);
        check("bp_idle", 32'(busy), 32'd0);

        // Stall during digit 3 with a 1-0-0-1 ready pattern.
        q.delete(); qc.delete();
        push_word(tbl[0].word, t);
        wait_bytes(2, 20);
        serial_ready = 1'b0;
        tick();
        check("stall_send_a", 32'(serial_send), 32'd1);
        check("stall_data_a", 32'(serial_dataToSend), 32'h33);
        tick();
        check("stall_send_b", 32'(serial_send), 32'd1);
        check("stall_data_b", 32'(serial_dataToSend), 32'h33);
        check("stall_count", 32'(q.size()), 32'd2);
        serial_ready = 1'b1;
        wait_bytes(9, 40);
        tick(); tick();
        check("stall_len", 32'(q.size()), 32'd9);
        check_line(0, 0);

        // Reset after the third digit of DEADBEEF.
        q.delete(); qc.delete();
        push_word(tbl[2].word, t);
        wait_bytes(3, 20);
        reset = 1'b1;
        tick();
        check("mid_rst_send", 32'(serial_send), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_rst_no_sep", 32'(q.size()), 32'd3);
        q.delete(); qc.delete();
        push_word(tbl[5].word, t);
        wait_bytes(9, 40);
        tick(); tick();
        check("mid_rst_len", 32'(q.size()), 32'd9);
        check_line(0, 5);

        // Second word pushed in the cycle IDLE pops the first (FIFO at one entry).
        q.delete(); qc.delete();
        push_word(tbl[3].word, t);
        push_word(tbl[1].word, t);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        wait_bytes(18, 60);
        check_line(0, 3);
        check_line(9, 1);
        // SEP transfer, one IDLE cycle, then the next first digit.
        if (qc.size() >= 10)
            check("pp_gap", 32'(qc[9] - qc[8]), 32'd2);
        tick(); tick();
        check("pp_len", 32'(q.size()), 32'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
